pe_sched: RTL
=============

Name: pe_sched

Overview:
- Round-robin scheduler that shares one 8-lane x 64-bit processing element among NREQ requesters.
- Each requester offers a 512-bit word through a valid/ready handshake. The scheduler issues granted words to the PE and tags each one with the requester ID.
- PE results are returned in order, with their ID, through a buffered response port.
- The PE has no backpressure, so a credit counter limits work in flight plus buffered results to MAX_INFLIGHT. This guarantees no result is ever dropped.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAX_INFLIGHT, 8, credit limit and depth of the tag and response FIFOs; power of 2, at least 2.
- ID_W, $clog2(NREQ), width of the requester ID.

Ports:
- CLK  in  1  clock; all logic is on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- REQ_VALID  in  NREQ  requester i offers a word.
- REQ_READY  out  NREQ  one-hot grant; a transfer occurs when REQ_VALID[i] and REQ_READY[i] are both high.
- REQ_DATA  in  NREQ x 512  packed as [NREQ-1:0][7:0][63:0]; requester payloads.
- PE_DIN  out  512  [7:0][63:0] word driven to the PE.
- PE_DVALID  out  1  PE_DIN is valid.
- PE_QOUT  in  512  [7:0][63:0] PE result.
- PE_QVALID  in  1  PE_QOUT is valid.
- RSP_DATA  out  512  head-of-queue result.
- RSP_ID  out  ID_W  requester that owns RSP_DATA.
- RSP_VALID  out  1  the response FIFO is not empty.
- RSP_READY  in  1  downstream accepts the response.
- BUSY  out  1  credit counter is nonzero.
- ERR  out  1  sticky: a PE result arrived with no matching tag.

Behaviour:
- Reset (RST_N low, asynchronous):
  - Round-robin pointer = 0; credit = 0.
  - Tag FIFO and response FIFO are emptied.
  - PE_DVALID=0, PE_DIN=0, RSP_VALID=0, BUSY=0, ERR=0.
  - Any in-flight work is discarded. The PE shares this reset.
- Arbitration (combinational, same cycle):
  - Requesters are searched starting at the pointer, wrapping at NREQ.
  - The first i with REQ_VALID[i]=1 gets REQ_READY[i]=1, but only if credit < MAX_INFLIGHT. Otherwise REQ_READY=0.
  - REQ_READY may depend combinationally on REQ_VALID. Requesters must not make REQ_VALID depend on REQ_READY.
  - A requester must hold REQ_DATA stable while REQ_VALID=1 and not yet granted.
- On a grant to requester i:
  - The pointer becomes (i+1) mod NREQ on the next edge. With no grant, the pointer holds.
  - ID i is pushed into the tag FIFO.
  - On the next edge, PE_DIN = REQ_DATA[i] and PE_DVALID = 1, giving 1-cycle issue latency.
  - With no grant, PE_DVALID = 0 and PE_DIN holds its last value.
- Throughput: one issue per cycle sustained while credits are available.
- Credit counter:
  - +1 on a grant; -1 when RSP_VALID and RSP_READY are both high.
  - Both in the same cycle leaves the count unchanged.
  - Range is 0..MAX_INFLIGHT; it never wraps.
- PE return path:
  - On PE_QVALID, the tag FIFO is popped and {ID, PE_QOUT} is pushed into the response FIFO.
  - The response FIFO cannot overflow, by the credit rule.
  - A result is visible at RSP_* on the cycle after PE_QVALID.
- PE latency: the PE may have any fixed latency of 0 or more cycles after PE_DVALID and must return results in order.
- Tag underflow: PE_QVALID with the tag FIFO empty sets ERR, which stays set until reset. The result is dropped and credit is unchanged.
- Response port:
  - RSP_DATA and RSP_ID are stable while RSP_VALID=1 and RSP_READY=0.
  - A push and a pop in the same cycle on a full or empty FIFO are both legal. Occupancy is unchanged by a simultaneous push and pop.
- Credit full: with credit = MAX_INFLIGHT, all REQ_READY = 0. If a response pops that cycle, the grant is made on the following cycle.
- Pointer wrap: a grant to requester NREQ-1 sets the pointer to 0.

Optional Feature:
- Macro: PE_SCHED_PERF_EN.
- When defined, two output ports are added:
  - ISSUE_CNT  out  32  number of grants.
  - STALL_CNT  out  32  cycles with any REQ_VALID high and credit = MAX_INFLIGHT.
- Both counters saturate at 0xFFFFFFFF and reset to 0.
- When not defined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- All four requesters hold REQ_VALID; RSP_READY=1; PE is a 1-cycle pass-through.
  -> Grants go 0,1,2,3,0,... with one grant per cycle.
  -> RSP_ID follows the same sequence.
  -> RSP_DATA equals the issued data.
- Only requester 2 valid; data lane0 = 0x0000_0001_DEAD_BEEF.
  -> PE_DVALID rises 1 cycle after the grant with that data.
  -> RSP_ID = 2 with matching data.
- RSP_READY=0 throughout, requester 0 always valid.
  -> Exactly 8 grants, then REQ_READY = 0.
  -> BUSY = 1.
  -> Raising RSP_READY for one cycle allows exactly one more grant.
- PE latency 5 with a burst of 8 words.
  -> Responses arrive in issue order.
  -> Credit returns to 0 and BUSY falls after the last pop.
- Assert PE_QVALID with no prior issue.
  -> ERR = 1 and stays set; RSP_VALID stays 0.
- RST_N asserted with 3 words in flight.
  -> All outputs take their reset values immediately.
  -> Pointer = 0: after release with all requesters valid, requester 0 is granted first.

Source files
------------

// File: rtl/pe_sched.sv
// Round-robin scheduler sharing one 8-lane x 64-bit PE among NREQ requesters, with credit flow control.
// Define PE_SCHED_PERF_EN to add the saturating ISSUE_CNT / STALL_CNT performance counters.
module pe_sched #(
    parameter int NREQ         = 4,
    parameter int MAX_INFLIGHT = 8,
    parameter int ID_W         = $clog2(NREQ)
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic [NREQ-1:0]             REQ_VALID,
    output logic [NREQ-1:0]             REQ_READY,
    input  logic [NREQ-1:0][7:0][63:0]  REQ_DATA,
    output logic [7:0][63:0]            PE_DIN,
    output logic                        PE_DVALID,
    input  logic [7:0][63:0]            PE_QOUT,
    input  logic                        PE_QVALID,
    output logic [7:0][63:0]            RSP_DATA,
    output logic [ID_W-1:0]             RSP_ID,
    output logic                        RSP_VALID,
    input  logic                        RSP_READY,
    output logic                        BUSY,
    output logic                        ERR
`ifdef PE_SCHED_PERF_EN
    ,
    output logic [31:0]                 ISSUE_CNT,
    output logic [31:0]                 STALL_CNT
`endif
);

    localparam int AW = $clog2(MAX_INFLIGHT);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    logic [ID_W-1:0]   r_ptr;
    logic [CW-1:0]     r_credit;
    logic [7:0][63:0]  r_din;
    logic              r_dvalid;
    logic              r_err;

    logic              w_credit_ok;
    logic              w_grant;
    logic [ID_W-1:0]   w_gid;

    assign w_credit_ok = (r_credit < CW'(MAX_INFLIGHT));

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        int idx;
        w_grant = 1'b0;
        w_gid   = '0;
        idx     = 0;
        // Scan from the farthest offset back toward the pointer; the nearest valid requester wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(r_ptr) + k) % NREQ;
            if (REQ_VALID[idx]) begin
                w_grant = w_credit_ok;
                w_gid   = ID_W'(idx);
            end
        end
    end

    assign REQ_READY = w_grant ? (NREQ'(1) << w_gid) : '0;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ptr    <= '0;
            r_din    <= '0;
            r_dvalid <= 1'b0;
        end else begin
            r_dvalid <= w_grant;
            if (w_grant) begin
                r_ptr <= (w_gid == ID_W'(NREQ - 1)) ? '0 : w_gid + 1'b1;
                r_din <= REQ_DATA[w_gid];
            end
        end
    end

    logic [ID_W-1:0]  r_tag_mem [MAX_INFLIGHT];
    logic [AW-1:0]    r_tag_wp, r_tag_rp;
    logic [AW:0]      r_tag_cnt;
    logic             w_tag_pop;
    logic             w_err_hit;

    logic [7:0][63:0] r_rsp_data [MAX_INFLIGHT];
    logic [ID_W-1:0]  r_rsp_id   [MAX_INFLIGHT];
    logic [AW-1:0]    r_rsp_wp, r_rsp_rp;
    logic [AW:0]      r_rsp_cnt;
    logic             w_rsp_pop;

    assign w_tag_pop = PE_QVALID && (r_tag_cnt != '0);
    assign w_err_hit = PE_QVALID && (r_tag_cnt == '0);
    assign w_rsp_pop = (r_rsp_cnt != '0) && RSP_READY;

    // NOTE: FIFO storage has no reset; only pointers and counts define which entries are valid.
    always_ff @(posedge CLK) begin
        if (w_grant) begin
            r_tag_mem[r_tag_wp] <= w_gid;
        end
        if (w_tag_pop) begin
            r_rsp_data[r_rsp_wp] <= PE_QOUT;
            r_rsp_id[r_rsp_wp]   <= r_tag_mem[r_tag_rp];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_tag_wp  <= '0;
            r_tag_rp  <= '0;
            r_tag_cnt <= '0;
            r_rsp_wp  <= '0;
            r_rsp_rp  <= '0;
            r_rsp_cnt <= '0;
            r_credit  <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_grant)   r_tag_wp <= r_tag_wp + 1'b1;
            if (w_tag_pop) r_tag_rp <= r_tag_rp + 1'b1;
            if (w_tag_pop) r_rsp_wp <= r_rsp_wp + 1'b1;
            if (w_rsp_pop) r_rsp_rp <= r_rsp_rp + 1'b1;
            r_tag_cnt <= r_tag_cnt + (AW+1)'(w_grant) - (AW+1)'(w_tag_pop);
            r_rsp_cnt <= r_rsp_cnt + (AW+1)'(w_tag_pop) - (AW+1)'(w_rsp_pop);
            // Credit covers both in-flight work and buffered results, so the response FIFO cannot overflow.
            r_credit  <= r_credit + CW'(w_grant) - CW'(w_rsp_pop);
            r_err     <= r_err | w_err_hit;
        end
    end

    assign PE_DIN    = r_din;
    assign PE_DVALID = r_dvalid;
    assign RSP_DATA  = r_rsp_data[r_rsp_rp];
    assign RSP_ID    = r_rsp_id[r_rsp_rp];
    assign RSP_VALID = (r_rsp_cnt != '0);
    assign BUSY      = (r_credit != '0);
    assign ERR       = r_err;

`ifdef PE_SCHED_PERF_EN
    logic [31:0] r_issue_cnt, r_stall_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_issue_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_grant && (r_issue_cnt != '1)) begin
                r_issue_cnt <= r_issue_cnt + 1'b1;
            end
            if ((|REQ_VALID) && (r_credit == CW'(MAX_INFLIGHT)) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign ISSUE_CNT = r_issue_cnt;
    assign STALL_CNT = r_stall_cnt;
`endif

endmodule
